// File: rtl/decode_fwd_stage.sv
// Decode/operand-select stage: RAW forwarding, load-use stall, ID/EX register.
// Optional WB-stage bypass enabled with `define DECODE_WB_BYPASS_EN.
module decode_fwd_stage #(
  parameter int DATA_WIDTH  = 64,
  parameter int REG_ADDR_W  = 5,
  parameter int ZERO_REG    = 31,
  parameter int ALUOP_W     = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_Aa,
  input  logic [REG_ADDR_W-1:0]  id_Ab,
  input  logic                   id_useA,
  input  logic                   id_useB,
  input  logic [REG_ADDR_W-1:0]  id_Aw,
  input  logic [DATA_WIDTH-1:0]  id_Da,
  input  logic [DATA_WIDTH-1:0]  id_Db,
  input  logic [DATA_WIDTH-1:0]  id_imm,
  input  logic                   id_ALUSrc,
  input  logic                   id_RegWrite,
  input  logic                   id_MemRead,
  input  logic                   id_MemWrite,
  input  logic [ALUOP_W-1:0]     id_ALUOp,
  input  logic                   id_flag_wr_en,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  ex_result,
  input  logic [REG_ADDR_W-1:0]  mem_Aw,
  input  logic                   mem_RegWrite,
  input  logic [DATA_WIDTH-1:0]  mem_result,
`ifdef DECODE_WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0]  wb_Aw,
  input  logic                   wb_RegWrite,
  input  logic [DATA_WIDTH-1:0]  wb_data,
`endif
  output logic                   stall,
  output logic                   ex_valid,
  output logic [DATA_WIDTH-1:0]  ex_opA,
  output logic [DATA_WIDTH-1:0]  ex_opB,
  output logic [DATA_WIDTH-1:0]  ex_storeData,
  output logic [REG_ADDR_W-1:0]  ex_Aw,
  output logic                   ex_RegWrite,
  output logic                   ex_MemRead,
  output logic                   ex_MemWrite,
  output logic                   ex_flag_wr_en,
  output logic [ALUOP_W-1:0]     ex_ALUOp,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic                   valid_q, valid_d;
  logic                   rw_q, rw_d;
  logic                   mr_q, mr_d;
  logic                   mw_q, mw_d;
  logic                   fw_q, fw_d;
  logic [ALUOP_W-1:0]     alu_q, alu_d;
  logic [REG_ADDR_W-1:0]  aw_q, aw_d;
  logic [DATA_WIDTH-1:0]  opa_q, opa_d;
  logic [DATA_WIDTH-1:0]  opb_q, opb_d;
  logic [DATA_WIDTH-1:0]  sd_q, sd_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic                   ex_fwd_ok;
  logic                   hit_exA, hit_exB;
  logic                   hit_memA, hit_memB;
  logic [DATA_WIDTH-1:0]  fwd_a, fwd_b;
  logic                   hazard, stall_int, bubble;

  // Loads in EX have no result yet; they are handled by the stall path.
  assign ex_fwd_ok = valid_q & rw_q & ~mr_q;
  assign hit_exA   = ex_fwd_ok & (aw_q == id_Aa) & (id_Aa != ZR);
  assign hit_exB   = ex_fwd_ok & (aw_q == id_Ab) & (id_Ab != ZR);
  assign hit_memA  = mem_RegWrite & (mem_Aw == id_Aa) & (id_Aa != ZR);
  assign hit_memB  = mem_RegWrite & (mem_Aw == id_Ab) & (id_Ab != ZR);

  always_comb begin
    fwd_a = id_Da;
    fwd_b = id_Db;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_RegWrite & (wb_Aw == id_Aa) & (id_Aa != ZR))
      fwd_a = wb_data;
    if (wb_RegWrite & (wb_Aw == id_Ab) & (id_Ab != ZR))
      fwd_b = wb_data;
`endif
    if (hit_memA) fwd_a = mem_result;
    if (hit_memB) fwd_b = mem_result;
    if (hit_exA)  fwd_a = ex_result;
    if (hit_exB)  fwd_b = ex_result;
  end

  assign hazard = id_valid & valid_q & mr_q & (aw_q != ZR) &
                  ((id_useA & (aw_q == id_Aa)) |
                   (id_useB & (aw_q == id_Ab)));
  assign stall_int = hazard & ~flush;
  assign stall     = stall_int & ~reset;
  assign bubble    = flush | ~id_valid | hazard;

  always_comb begin
    valid_d = 1'b0;
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    fw_d    = 1'b0;
    alu_d   = alu_q;
    aw_d    = aw_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;
    if (!stall_int) begin
      alu_d = id_ALUOp;
      aw_d  = id_Aw;
      opa_d = fwd_a;
      opb_d = id_ALUSrc ? id_imm : fwd_b;
      sd_d  = fwd_b;
    end
    if (!bubble) begin
      valid_d = 1'b1;
      rw_d    = id_RegWrite;
      mr_d    = id_MemRead;
      mw_d    = id_MemWrite;
      fw_d    = id_flag_wr_en;
    end
    if (stall_int && cnt_q != CNT_MAX)
      cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      fw_q    <= 1'b0;
      alu_q   <= '0;
      aw_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      fw_q    <= fw_d;
      alu_q   <= alu_d;
      aw_q    <= aw_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_RegWrite   = rw_q;
  assign ex_MemRead    = mr_q;
  assign ex_MemWrite   = mw_q;
  assign ex_flag_wr_en = fw_q;
  assign ex_ALUOp      = alu_q;
  assign ex_Aw         = aw_q;
  assign ex_opA        = opa_q;
  assign ex_opB        = opb_q;
  assign ex_storeData  = sd_q;
  assign stall_count   = cnt_q;

endmodule
